// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM state encoding
// and the default access timeout.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int TMO_DEFAULT = 15;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection. Purely combinational.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       winner
);

   // Sole requester wins; on contention the one not served last time wins
   always_comb begin
      valid  = |req;
      winner = 1'b0;
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_grant;
         default: winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one SRAM controller port. Each access is
// IDLE -> ACCESS -> RESP; the controller must go busy (mem_ready low) within
// TMO ACCESS cycles, otherwise the access is ended with zero data and a
// sticky timeout flag.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int WDATA_W = 32,
   parameter int RDATA_W = 64,
   parameter int TMO     = TMO_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en0,
   input  logic               wr_en0,
   input  logic [ADDR_W-1:0]  addr0,
   input  logic [WDATA_W-1:0] wdata0,
   output logic [RDATA_W-1:0] rdata0,
   output logic               ready0,
   input  logic               rd_en1,
   input  logic               wr_en1,
   input  logic [ADDR_W-1:0]  addr1,
   input  logic [WDATA_W-1:0] wdata1,
   output logic [RDATA_W-1:0] rdata1,
   output logic               ready1,
   output logic               mem_read_en,
   output logic               mem_write_en,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [WDATA_W-1:0] mem_write_data,
   input  logic [RDATA_W-1:0] mem_read_data,
   input  logic               mem_ready,
   output logic               grant,
   output logic               tmo_err
);

   localparam int CNT_W = $clog2(TMO + 1);

   state_t             state;
   logic               last_grant;
   logic               started;
   logic [CNT_W-1:0]   cnt;
   logic [RDATA_W-1:0] rdata_q;

   logic [1:0]         req;
   logic               pick_valid;
   logic               pick_winner;
   logic               sel_write;
   logic [ADDR_W-1:0]  sel_addr;
   logic [WDATA_W-1:0] sel_wdata;
   logic               done_ok;
   logic               done_tmo;

   rr_pick2 u_pick (
      .req        (req),
      .last_grant (last_grant),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   // Requests per port and the winner's operation; read wins over write
   always_comb begin
      req = {rd_en1 | wr_en1, rd_en0 | wr_en0};
      if (pick_winner) begin
         sel_write = wr_en1 & ~rd_en1;
         sel_addr  = addr1;
         sel_wdata = wdata1;
      end else begin
         sel_write = wr_en0 & ~rd_en0;
         sel_addr  = addr0;
         sel_wdata = wdata0;
      end
   end

   // Access termination: normal completion after busy, or busy never seen
   always_comb begin
      done_ok  = (state == ACCESS) && started && mem_ready;
      done_tmo = (state == ACCESS) && !started && mem_ready &&
                 (cnt == CNT_W'(TMO - 1));
   end

   // Read data is presented only during the granted requester's ready pulse
   assign rdata0 = ready0 ? rdata_q : '0;
   assign rdata1 = ready1 ? rdata_q : '0;

   // Arbiter FSM with registered controller-side and requester-side outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         grant          <= 1'b0;
         started        <= 1'b0;
         cnt            <= '0;
         rdata_q        <= '0;
         tmo_err        <= 1'b0;
         ready0         <= 1'b0;
         ready1         <= 1'b0;
         mem_read_en    <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
      end else begin
         ready0 <= 1'b0;
         ready1 <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state          <= ACCESS;
                  last_grant     <= pick_winner;
                  grant          <= pick_winner;
                  started        <= 1'b0;
                  cnt            <= '0;
                  mem_read_en    <= ~sel_write;
                  mem_write_en   <= sel_write;
                  mem_address    <= sel_addr;
                  mem_write_data <= sel_wdata;
               end
            end
            ACCESS: begin
               if (!started) begin
                  cnt <= cnt + 1'b1;
                  if (!mem_ready) started <= 1'b1;
               end
               if (done_ok || done_tmo) begin
                  state        <= RESP;
                  mem_read_en  <= 1'b0;
                  mem_write_en <= 1'b0;
                  rdata_q      <= done_ok ? mem_read_data : '0;
                  if (done_tmo) tmo_err <= 1'b1;
                  ready0       <= ~grant;
                  ready1       <= grant;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level reference model, cycle-by-cycle
// compare, a simple SRAM controller responder and directed scenarios.
module tb_sram_arbiter;

   localparam int ADDR_W  = 32;
   localparam int WDATA_W = 32;
   localparam int RDATA_W = 64;
   localparam int TMO     = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               rd_en0, wr_en0, rd_en1, wr_en1;
   logic [ADDR_W-1:0]  addr0, addr1;
   logic [WDATA_W-1:0] wdata0, wdata1;
   logic [RDATA_W-1:0] rdata0, rdata1;
   logic               ready0, ready1;
   logic               mem_read_en, mem_write_en;
   logic [ADDR_W-1:0]  mem_address;
   logic [WDATA_W-1:0] mem_write_data;
   logic [RDATA_W-1:0] mem_read_data;
   logic               mem_ready;
   logic               grant, tmo_err;

   always #5 clk = ~clk;

   sram_arbiter #(
      .ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .RDATA_W(RDATA_W), .TMO(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_en0(rd_en0), .wr_en0(wr_en0), .addr0(addr0), .wdata0(wdata0),
      .rdata0(rdata0), .ready0(ready0),
      .rd_en1(rd_en1), .wr_en1(wr_en1), .addr1(addr1), .wdata1(wdata1),
      .rdata1(rdata1), .ready1(ready1),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .mem_ready(mem_ready),
      .grant(grant), .tmo_err(tmo_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Controller responder: busy for the first `busy` cycles of each access,
   // never busy when busy == 0 (forces the timeout path).
   int busy = 0;
   int acc_cyc = 0;
   initial begin
      mem_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (mem_read_en || mem_write_en) acc_cyc++;
         else acc_cyc = 0;
         mem_ready = !(acc_cyc >= 1 && acc_cyc <= busy);
      end
   end

   // Reference model: each access occupies a known number of cycles given
   // the responder's busy setting, followed by one response cycle and one
   // idle cycle before the next arbitration.
   bit                 m_live = 1'b0;
   int                 m_left = 0;
   bit                 m_resp = 1'b0;
   bit                 m_lg = 1'b1;
   int                 m_who = 0;
   bit                 m_to = 1'b0;
   logic               e_rd = 0, e_wr = 0, e_rdy0 = 0, e_rdy1 = 0, e_grant = 0, e_tmo = 0;
   logic [ADDR_W-1:0]  e_addr = '0;
   logic [WDATA_W-1:0] e_wdata = '0;
   logic [RDATA_W-1:0] e_rdata0 = '0, e_rdata1 = '0;

   always @(posedge clk) begin
      logic [RDATA_W-1:0] d;
      bit want0, want1, wr;
      if (rst) begin
         m_live = 1'b1; m_left = 0; m_resp = 1'b0; m_lg = 1'b1;
         e_rd = 0; e_wr = 0; e_rdy0 = 0; e_rdy1 = 0; e_grant = 0; e_tmo = 0;
         e_rdata0 = '0; e_rdata1 = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            e_rd = 0; e_wr = 0; m_resp = 1'b1;
            d = m_to ? '0 : mem_read_data;
            if (m_to) e_tmo = 1'b1;
            if (m_who == 0) begin e_rdy0 = 1; e_rdata0 = d; end
            else begin e_rdy1 = 1; e_rdata1 = d; end
         end
      end else if (m_resp) begin
         m_resp = 1'b0;
         e_rdy0 = 0; e_rdy1 = 0; e_rdata0 = '0; e_rdata1 = '0;
      end else begin
         want0 = rd_en0 || wr_en0;
         want1 = rd_en1 || wr_en1;
         if (want0 || want1) begin
            if (want0 && want1) m_who = m_lg ? 0 : 1;
            else m_who = want1 ? 1 : 0;
            m_lg    = (m_who == 1);
            e_grant = (m_who == 1);
            wr      = (m_who == 1) ? (wr_en1 && !rd_en1) : (wr_en0 && !rd_en0);
            e_rd    = !wr;
            e_wr    = wr;
            e_addr  = (m_who == 1) ? addr1 : addr0;
            e_wdata = (m_who == 1) ? wdata1 : wdata0;
            m_to    = (busy == 0);
            m_left  = m_to ? TMO : busy + 1;
         end
      end
   end

   // Per-cycle compare against the model plus statistics for literal checks
   int                 n_rdy0 = 0, n_rdy1 = 0, n_wr = 0, cur_len = 0, last_len = 0;
   logic [RDATA_W-1:0] last_rd0 = '0, last_rd1 = '0;
   logic [WDATA_W-1:0] last_wdata = '0;
   logic [ADDR_W-1:0]  last_addr = '0;
   int                 glog[$];

   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            chk1("mem_read_en", mem_read_en, e_rd);
            chk1("mem_write_en", mem_write_en, e_wr);
            if (e_rd || e_wr) chk("mem_address", 64'(mem_address), 64'(e_addr));
            if (e_wr) chk("mem_write_data", 64'(mem_write_data), 64'(e_wdata));
            chk1("ready0", ready0, e_rdy0);
            chk1("ready1", ready1, e_rdy1);
            chk("rdata0", rdata0, e_rdata0);
            chk("rdata1", rdata1, e_rdata1);
            chk1("grant", grant, e_grant);
            chk1("tmo_err", tmo_err, e_tmo);
         end
         if (mem_read_en === 1'b1 || mem_write_en === 1'b1) begin
            cur_len++;
            last_addr = mem_address;
         end
         if (mem_write_en === 1'b1) begin
            n_wr++;
            last_wdata = mem_write_data;
         end
         if (ready0 === 1'b1) begin
            n_rdy0++; last_rd0 = rdata0; glog.push_back(int'(grant));
            last_len = cur_len; cur_len = 0;
         end
         if (ready1 === 1'b1) begin
            n_rdy1++; last_rd1 = rdata1; glog.push_back(int'(grant));
            last_len = cur_len; cur_len = 0;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      glog.delete();
      n_rdy0 = 0; n_rdy1 = 0; n_wr = 0; cur_len = 0; last_len = 0;
   endtask

   task automatic wait_ready(input int who, input int budget);
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         if ((who == 0 && ready0 === 1'b1) || (who == 1 && ready1 === 1'b1)) begin
            if (who == 0) begin rd_en0 = 1'b0; wr_en0 = 1'b0; end
            else begin rd_en1 = 1'b0; wr_en1 = 1'b0; end
            return;
         end
         k++;
         if (k >= budget) begin
            total++; bad++;
            $display("FAIL wait_ready%0d: ready got 0 want 1 within %0d cycles", who, budget);
            return;
         end
      end
   endtask

   function automatic int glog_at(input int i);
      return (glog.size() > i) ? glog[i] : -1;
   endfunction

   initial begin
      int seen;
      int k;
      int fair[4];
      fair = '{0, 1, 0, 1};
      rst = 1'b1;
      rd_en0 = 0; wr_en0 = 0; rd_en1 = 0; wr_en1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      mem_read_data = '0;
      cycles(2);
      rst = 1'b0;

      // Reset state
      chk1("rst_ready0", ready0, 1'b0);
      chk1("rst_ready1", ready1, 1'b0);
      chk1("rst_mem_read_en", mem_read_en, 1'b0);
      chk1("rst_grant", grant, 1'b0);
      chk1("rst_tmo_err", tmo_err, 1'b0);

      // Single read from requester 0
      clear_logs();
      busy = 6;
      mem_read_data = 64'h1122334455667788;
      addr0 = 32'h400;
      rd_en0 = 1'b1;
      wait_ready(0, 40);
      cycles(2);
      chki("t1_ready0_count", n_rdy0, 1);
      chki("t1_ready1_count", n_rdy1, 0);
      chk("t1_rdata0", last_rd0, 64'h1122334455667788);
      chk("t1_address", 64'(last_addr), 64'h400);
      chki("t1_access_len", last_len, 7);
      chki("t1_no_write", n_wr, 0);

      // Contention after reset: read from 0, write from 1
      do_reset();
      clear_logs();
      busy = 3;
      mem_read_data = 64'hA5A5_5A5A_0F0F_F0F0;
      addr0 = 32'h100; addr1 = 32'h200; wdata1 = 32'hCAFEF00D;
      rd_en0 = 1'b1; wr_en1 = 1'b1;
      wait_ready(0, 40);
      wait_ready(1, 40);
      cycles(2);
      chki("t2_grant_first", glog_at(0), 0);
      chki("t2_grant_second", glog_at(1), 1);
      chk("t2_wdata", 64'(last_wdata), 64'hCAFEF00D);
      chk("t2_waddr", 64'(last_addr), 64'h200);
      chki("t2_write_cycles", n_wr, 4);

      // Fairness: both hold requests for four accesses
      do_reset();
      clear_logs();
      busy = 2;
      addr0 = 32'h10; addr1 = 32'h20;
      rd_en0 = 1'b1; rd_en1 = 1'b1;
      seen = 0;
      k = 0;
      while (seen < 4 && k < 100) begin
         @(negedge clk);
         if (ready0 === 1'b1 || ready1 === 1'b1) seen++;
         k++;
      end
      rd_en0 = 1'b0; rd_en1 = 1'b0;
      chki("t3_accesses", seen, 4);
      cycles(2);
      for (int i = 0; i < 4; i++) chki($sformatf("t3_grant%0d", i), glog_at(i), fair[i]);

      // Simultaneous read+write on one requester is a read; minimum turnaround
      clear_logs();
      busy = 1;
      addr1 = 32'h30;
      rd_en1 = 1'b1; wr_en1 = 1'b1;
      wait_ready(1, 20);
      cycles(2);
      chki("t3b_no_write", n_wr, 0);
      chki("t3b_grant", glog_at(0), 1);
      chki("t3b_access_len", last_len, 2);

      // Timeout: controller never goes busy
      clear_logs();
      busy = 0;
      mem_read_data = 64'hDEAD_BEEF_0123_4567;
      addr1 = 32'h55;
      rd_en1 = 1'b1;
      wait_ready(1, 60);
      cycles(2);
      chki("t4_access_len", last_len, 15);
      chk("t4_rdata1", last_rd1, 64'h0);
      chk1("t4_tmo_err", tmo_err, 1'b1);
      busy = 2;
      rd_en0 = 1'b1;
      wait_ready(0, 40);
      cycles(3);
      chk1("t4_tmo_sticky", tmo_err, 1'b1);
      chk("t4_rdata0_after", last_rd0, 64'hDEAD_BEEF_0123_4567);
      do_reset();
      chk1("t4_tmo_cleared", tmo_err, 1'b0);

      // Reset in the third ACCESS cycle
      clear_logs();
      busy = 8;
      addr1 = 32'h77;
      rd_en1 = 1'b1;
      k = 0;
      while (mem_read_en !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk1("t5_access_started", mem_read_en, 1'b1);
      cycles(2);
      rst = 1'b1;
      cycles(1);
      chk1("t5_rd_en_off", mem_read_en, 1'b0);
      chk1("t5_wr_en_off", mem_write_en, 1'b0);
      chk1("t5_no_ready1", ready1, 1'b0);
      rst = 1'b0;
      rd_en0 = 1'b1;
      addr0 = 32'h88;
      wait_ready(0, 40);
      wait_ready(1, 40);
      cycles(2);
      chki("t5_first_grant", glog_at(0), 0);
      chki("t5_second_grant", glog_at(1), 1);
      chki("t5_ready1_count", n_rdy1, 1);

      cycles(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of requesters and SRAM controller port.
REQ-002 Parameter WDATA_W, 32, write-data width.
REQ-003 Parameter RDATA_W, 64, read-data width.
REQ-004 Parameter TMO, 15, cycles allowed in ACCESS before the controller must show busy (mem_ready low).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rd_en0/rd_en1  in  1  read request, requester 0/1; held until that requester's ready.
REQ-008 wr_en0/wr_en1  in  1  write request, requester 0/1; held until ready.
REQ-009 addr0/addr1  in  ADDR_W  request address.
REQ-010 wdata0/wdata1  in  WDATA_W  write data.
REQ-011 rdata0/rdata1  out  RDATA_W  read data; valid only in the cycle that requester's ready is high.
REQ-012 ready0/ready1  out  1  one-cycle completion pulse to requester.
REQ-013 mem_read_en/mem_write_en  out  1  to SRAM controller.
REQ-014 mem_address  out  ADDR_W; mem_write_data  out  WDATA_W.
REQ-015 mem_read_data  in  RDATA_W; mem_ready  in  1  controller ready (low while busy).
REQ-016 grant  out  1  index of the current or last-served requester; tmo_err  out  1  sticky timeout flag.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS when any request is present.
- ACCESS -> RESP on completion (REQ-021) or timeout (REQ-022).
- RESP -> IDLE unconditionally.
REQ-018 Arbitration in IDLE: a sole requester wins; when both request, the winner is the requester not equal to last_grant (round robin). last_grant updates on entry to ACCESS.
REQ-019 Within one requester, simultaneous rd_en and wr_en are treated as a read.
REQ-020 On entry to ACCESS, the winner's op, addr and wdata are latched. In ACCESS, the latched op drives exactly one of mem_read_en/mem_write_en high, and mem_address/mem_write_data come from the latches. Both enables are low in IDLE and RESP.
REQ-021 A started flag is cleared on entry to ACCESS and set when mem_ready=0 is sampled in ACCESS. Completion is ACCESS && started && mem_ready=1. On completion, mem_read_data is captured into the rdata register.
REQ-022 A counter is cleared on entry to ACCESS and increments each ACCESS cycle while started=0. If it reaches TMO: go to RESP, set tmo_err, and the captured rdata is all-zero.
REQ-023 In RESP, only the granted requester's ready is 1, and its rdata equals the captured data. Ungranted ready is always 0.
REQ-024 Minimum turnaround: request seen in IDLE at cycle N, ACCESS from N+1, ready pulse no earlier than N+3.
REQ-025 A requester that drops its request mid-ACCESS does not abort the access. The access completes and the ready pulse is still issued.
REQ-026 A request arriving from the other requester during ACCESS/RESP waits. It is considered in the IDLE cycle following RESP.
REQ-027 rdata0/rdata1 outputs are 0 whenever the matching ready is 0.

Reset
REQ-028 On rst at a clock edge: state=IDLE, last_grant=1 (requester 0 wins first contention), started=0, counter=0, rdata register=0, tmo_err=0. All outputs are 0 the following cycle.
REQ-029 Reset mid-ACCESS abandons the access immediately; no ready pulse is issued.

Structure
REQ-030 State encoding (2-bit) and the TMO default shall reside in package sram_arb_pkg.
REQ-031 Winner selection shall be sub-module rr_pick2 (inputs: req[1:0], last_grant; outputs: valid, winner). It is purely combinational.

Verification
REQ-032 Single read: rd_en0=1, addr0=0x400; controller model holds mem_ready low 6 cycles, data 0x1122334455667788 -> mem_read_en=1 with mem_address=0x400 throughout; ready0 pulses once with rdata0=0x1122334455667788; ready1 stays 0.
REQ-033 Contention after reset: rd_en0 and wr_en1 both asserted in the same cycle -> requester 0 served first, then requester 1. mem_write_en=1 with wdata1 on the bus during the second access; grant sequence 0,1.
REQ-034 Fairness: both requesters hold requests continuously for 4 accesses -> grant alternates 0,1,0,1; no back-to-back grant to the same requester.
REQ-035 Timeout: mem_ready held at 1 for the entire access -> RESP after 15 ACCESS cycles; ready pulse with rdata=0; tmo_err=1 stays set until rst.
REQ-036 Reset mid-ACCESS: rst asserted in the third ACCESS cycle -> next cycle state=IDLE, both enables 0, no ready pulse; requester 0 wins the next contention.
